// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: FSM states, port select, request record.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    SEL_D = 1'b0,
    SEL_I = 1'b1
  } port_sel_e;

  localparam logic [2:0] SIZ_WORD = 3'b100;

  typedef struct packed {
    logic [31:0] adr;
    logic        load;
    logic [31:0] wdata;
    logic [2:0]  siz;
  } mem_req_t;

  // Data port has priority unless the fetch port has been starved long enough.
  function automatic port_sel_e pick_winner(input logic pend_i, input logic pend_d,
                                            input logic starved);
    return (pend_i && (!pend_d || starved)) ? SEL_I : SEL_D;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Pending flag plus latched request fields for one requesting port.
module arb_req_latch
  import mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_start,
  input  mem_req_t i_req,
  input  logic     i_inflight,
  input  logic     i_clr,
  output logic     o_pend,
  output mem_req_t o_req
);

  logic     r_pend;
  mem_req_t r_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_req  <= '0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end else if (i_start && !r_pend && !i_inflight) begin
      // A start while the port is busy is dropped; the original request stands.
      r_pend <= 1'b1;
      r_req  <= i_req;
    end
  end

  assign o_pend = r_pend;
  assign o_req  = r_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory access channel between the fetch (I) and load/store (D) ports.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_start,
  input  logic [31:0] I_adr,
  output logic [31:0] I_out,
  output logic        I_busy,
  output logic        I_done,
  input  logic        D_start,
  input  logic [31:0] D_adr,
  input  logic        D_load,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_siz,
  output logic [31:0] D_out,
  output logic        D_busy,
  output logic        D_done,
  output logic        M_start,
  output logic [31:0] M_adr,
  output logic        M_load,
  output logic [31:0] M_in,
  output logic [2:0]  M_siz,
  input  logic [31:0] M_out,
  input  logic        M_busy,
  input  logic        M_done
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e  r_state;
  port_sel_e   r_sel;
  logic [3:0]  r_starve_cnt;
  logic        r_m_start;
  logic [31:0] r_m_adr;
  logic        r_m_load;
  logic [31:0] r_m_in;
  logic [2:0]  r_m_siz;
  logic [31:0] r_i_out;
  logic [31:0] r_d_out;
  logic        r_i_done;
  logic        r_d_done;

  logic        w_i_pend;
  logic        w_d_pend;
  mem_req_t    w_i_req;
  mem_req_t    w_d_req;
  mem_req_t    w_i_new;
  mem_req_t    w_d_new;
  mem_req_t    w_win_req;
  logic        w_i_inflight;
  logic        w_d_inflight;
  logic        w_i_clr;
  logic        w_d_clr;
  logic        w_starved;
  port_sel_e   w_pick;

  // Fetches are always word reads; fixing the fields here keeps the grant path uniform.
  assign w_i_new = '{adr: I_adr, load: 1'b1, wdata: '0, siz: SIZ_WORD};
  assign w_d_new = '{adr: D_adr, load: D_load, wdata: D_in, siz: D_siz};

  assign w_i_inflight = (r_state != ST_IDLE) && (r_sel == SEL_I);
  assign w_d_inflight = (r_state != ST_IDLE) && (r_sel == SEL_D);
  assign w_i_clr      = (r_state == ST_RESP) && (r_sel == SEL_I);
  assign w_d_clr      = (r_state == ST_RESP) && (r_sel == SEL_D);

  arb_req_latch u_i_latch (
    .clk        (clk),
    .rst        (rst),
    .i_start    (I_start),
    .i_req      (w_i_new),
    .i_inflight (w_i_inflight),
    .i_clr      (w_i_clr),
    .o_pend     (w_i_pend),
    .o_req      (w_i_req)
  );

  arb_req_latch u_d_latch (
    .clk        (clk),
    .rst        (rst),
    .i_start    (D_start),
    .i_req      (w_d_new),
    .i_inflight (w_d_inflight),
    .i_clr      (w_d_clr),
    .o_pend     (w_d_pend),
    .o_req      (w_d_req)
  );

  assign w_starved = w_i_pend && (r_starve_cnt == LIMIT);
  assign w_pick    = pick_winner(w_i_pend, w_d_pend, w_starved);
  assign w_win_req = (w_pick == SEL_I) ? w_i_req : w_d_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= SEL_D;
      r_starve_cnt <= '0;
      r_m_start    <= 1'b0;
      r_m_adr      <= '0;
      r_m_load     <= 1'b0;
      r_m_in       <= '0;
      r_m_siz      <= '0;
      r_i_out      <= '0;
      r_d_out      <= '0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((w_i_pend || w_d_pend) && !M_busy) begin
            r_sel     <= w_pick;
            r_m_start <= 1'b1;
            r_m_adr   <= w_win_req.adr;
            r_m_load  <= w_win_req.load;
            r_m_in    <= w_win_req.wdata;
            r_m_siz   <= w_win_req.siz;
            r_state   <= ST_ISSUE;
            if (w_pick == SEL_I) begin
              r_starve_cnt <= '0;
            end else if (w_i_pend && (r_starve_cnt != LIMIT)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          r_m_start <= 1'b0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (M_done) begin
            if (r_sel == SEL_I) begin
              r_i_out  <= M_out;
              r_i_done <= 1'b1;
            end else begin
              r_d_out  <= M_out;
              r_d_done <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_i_done <= 1'b0;
          r_d_done <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign I_out   = r_i_out;
  assign I_done  = r_i_done;
  assign I_busy  = w_i_pend | w_i_inflight;
  assign D_out   = r_d_out;
  assign D_done  = r_d_done;
  assign D_busy  = w_d_pend | w_d_inflight;
  assign M_start = r_m_start;
  assign M_adr   = r_m_adr;
  assign M_load  = r_m_load;
  assign M_in    = r_m_in;
  assign M_siz   = r_m_siz;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        I_start = 1'b0;
  logic [31:0] I_adr = '0;
  logic [31:0] I_out;
  logic        I_busy;
  logic        I_done;
  logic        D_start = 1'b0;
  logic [31:0] D_adr = '0;
  logic        D_load = 1'b0;
  logic [31:0] D_in = '0;
  logic [2:0]  D_siz = '0;
  logic [31:0] D_out;
  logic        D_busy;
  logic        D_done;
  logic        M_start;
  logic [31:0] M_adr;
  logic        M_load;
  logic [31:0] M_in;
  logic [2:0]  M_siz;
  logic [31:0] M_out = '0;
  logic        M_busy = 1'b0;
  logic        M_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .I_start(I_start), .I_adr(I_adr), .I_out(I_out), .I_busy(I_busy), .I_done(I_done),
    .D_start(D_start), .D_adr(D_adr), .D_load(D_load), .D_in(D_in), .D_siz(D_siz),
    .D_out(D_out), .D_busy(D_busy), .D_done(D_done),
    .M_start(M_start), .M_adr(M_adr), .M_load(M_load), .M_in(M_in), .M_siz(M_siz),
    .M_out(M_out), .M_busy(M_busy), .M_done(M_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_mstart(input string tag);
    int n = 0;
    while (M_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " M_start seen"}, 32'(M_start), 32'd1);
  endtask

  // Memory completes `dly` cycles after entry; returns in the cycle done is visible.
  task automatic mem_respond(input logic [31:0] data, input int dly);
    repeat (dly) tick();
    M_out  = data;
    M_done = 1'b1;
    tick();
    M_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst I_busy", 32'(I_busy), 0);
    chk("rst D_busy", 32'(D_busy), 0);
    chk("rst M_start", 32'(M_start), 0);
    chk("rst M_adr", M_adr, 0);
    chk("rst I_out", I_out, 0);
    rst = 1'b0;
    tick();

    // 1. Single fetch, exact latency
    I_start = 1'b1; I_adr = 32'h100;
    tick();
    I_start = 1'b0;
    chk("t1 I_busy", 32'(I_busy), 1);
    chk("t1 M_start c1", 32'(M_start), 0);
    tick();
    chk("t1 M_start c2", 32'(M_start), 1);
    chk("t1 M_adr", M_adr, 32'h100);
    chk("t1 M_load", 32'(M_load), 1);
    chk("t1 M_siz", 32'(M_siz), 32'h4);
    tick();
    chk("t1 M_start pulse", 32'(M_start), 0);
    mem_respond(32'hDEADBEEF, 2);
    chk("t1 I_done", 32'(I_done), 1);
    chk("t1 I_out", I_out, 32'hDEADBEEF);
    chk("t1 D_done", 32'(D_done), 0);
    tick();
    chk("t1 I_done pulse", 32'(I_done), 0);
    chk("t1 I_out held", I_out, 32'hDEADBEEF);
    chk("t1 I_busy clr", 32'(I_busy), 0);

    // 2. Simultaneous starts, D first
    I_start = 1'b1; I_adr = 32'h10;
    D_start = 1'b1; D_adr = 32'h200; D_load = 1'b1; D_siz = 3'b010; D_in = 32'h0;
    tick();
    I_start = 1'b0; D_start = 1'b0;
    chk("t2 both busy", {30'd0, I_busy, D_busy}, 32'h3);
    wait_mstart("t2 D");
    chk("t2 D M_adr", M_adr, 32'h200);
    chk("t2 D M_siz", 32'(M_siz), 32'h2);
    mem_respond(32'hAAAA0001, 1);
    chk("t2 D_done", 32'(D_done), 1);
    chk("t2 D_out", D_out, 32'hAAAA0001);
    chk("t2 I_done quiet", 32'(I_done), 0);
    tick();
    wait_mstart("t2 I");
    chk("t2 I M_adr", M_adr, 32'h10);
    chk("t2 I M_siz", 32'(M_siz), 32'h4);
    chk("t2 I M_load", 32'(M_load), 1);
    mem_respond(32'hBBBB0002, 1);
    chk("t2 I_done", 32'(I_done), 1);
    chk("t2 I_out", I_out, 32'hBBBB0002);
    chk("t2 D_done quiet", 32'(D_done), 0);
    chk("t2 D_out held", D_out, 32'hAAAA0001);
    tick();

    // 3. Starvation: I forced through after 4 D grants
    M_busy = 1'b1;
    I_start = 1'b1; I_adr = 32'h800;
    D_start = 1'b1; D_adr = 32'hA00; D_load = 1'b1; D_siz = 3'b010;
    tick();
    I_start = 1'b0; D_start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      M_busy = 1'b0;
      wait_mstart("t3 D");
      chk("t3 D M_adr", M_adr, 32'hA00 + 32'(g));
      M_busy = 1'b1;
      mem_respond(32'hC0 + 32'(g), 1);
      chk("t3 D_done", 32'(D_done), 1);
      tick();
      D_start = 1'b1; D_adr = 32'hA01 + 32'(g);
      tick();
      D_start = 1'b0;
    end
    chk("t3 starve cnt", 32'(dut.r_starve_cnt), 4);
    M_busy = 1'b0;
    wait_mstart("t3 I");
    chk("t3 I M_adr", M_adr, 32'h800);
    chk("t3 starve clr", 32'(dut.r_starve_cnt), 0);
    mem_respond(32'h11112222, 1);
    chk("t3 I_done", 32'(I_done), 1);
    chk("t3 I_out", I_out, 32'h11112222);
    tick();
    wait_mstart("t3 D last");
    chk("t3 D last M_adr", M_adr, 32'hA04);
    mem_respond(32'h33334444, 1);
    chk("t3 D last done", 32'(D_done), 1);
    tick();

    // 4. Store
    D_start = 1'b1; D_load = 1'b0; D_adr = 32'h300; D_in = 32'h12345678; D_siz = 3'b010;
    tick();
    D_start = 1'b0;
    wait_mstart("t4");
    chk("t4 M_adr", M_adr, 32'h300);
    chk("t4 M_load", 32'(M_load), 0);
    chk("t4 M_in", M_in, 32'h12345678);
    chk("t4 M_siz", 32'(M_siz), 32'h2);
    mem_respond(32'h0, 1);
    chk("t4 D_done", 32'(D_done), 1);
    tick();
    chk("t4 D_busy clr", 32'(D_busy), 0);

    // 5. Memory busy holds off issue; duplicate fetch start ignored
    M_busy = 1'b1;
    I_start = 1'b1; I_adr = 32'h500;
    tick();
    I_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5 no M_start", 32'(M_start), 0);
      if (i == 2) begin
        I_start = 1'b1; I_adr = 32'h600;
      end else begin
        I_start = 1'b0;
      end
      tick();
    end
    I_start = 1'b0;
    chk("t5 I_busy", 32'(I_busy), 1);
    M_busy = 1'b0;
    tick();
    chk("t5 M_start", 32'(M_start), 1);
    chk("t5 M_adr kept", M_adr, 32'h500);
    mem_respond(32'h55555555, 1);
    chk("t5 I_out", I_out, 32'h55555555);
    tick(); tick(); tick();
    chk("t5 no dup issue", {30'd0, M_start, I_busy}, 0);

    // 6. Reset during WAIT
    I_start = 1'b1; I_adr = 32'h700;
    tick();
    I_start = 1'b0;
    wait_mstart("t6");
    tick();
    rst = 1'b1;
    #1;
    chk("t6 async I_busy", 32'(I_busy), 0);
    chk("t6 async M_adr", M_adr, 0);
    chk("t6 async M_load", 32'(M_load), 0);
    chk("t6 async M_siz", 32'(M_siz), 0);
    chk("t6 async I_out", I_out, 0);
    tick();
    rst = 1'b0;
    tick();
    M_out = 32'h77777777; M_done = 1'b1;
    tick();
    M_done = 1'b0;
    chk("t6 no done", {30'd0, I_done, D_done}, 0);
    tick();
    chk("t6 no done later", {30'd0, I_done, D_done}, 0);
    chk("t6 I_out kept 0", I_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
